// File: rtl/line_engine_pkg.sv
// Shared types and constants for the burst line engine: FSM states, burst geometry,
// FIFO command encoding and the pixel-valid to byte-mask helper.
package line_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP,
        ST_FLUSH0,
        ST_FLUSH1
    } le_state_t;

    localparam int PIX_PER_BLK = 8;
    localparam int BEATS_PER_BURST = 2;
    localparam logic [15:0] MASK_ALL_OFF = 16'hFFFF;
    localparam logic [2:0] AF_CMD_WRITE = 3'b000;

    // Bit i of pix_valid is pixel i of the beat; pixel 0 owns the top nibble.
    function automatic logic [15:0] expand_mask(input logic [3:0] pix_valid);
        logic [15:0] m;
        m = MASK_ALL_OFF;
        for (int i = 0; i < 4; i++) begin
            if (pix_valid[i]) begin
                m[15-4*i -: 4] = 4'h0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham walker: endpoints are captured on load, normalised during setup
// (steep swap, left-to-right order), then one pixel per cycle while advance is high.
module line_stepper #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int W   = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           setup,
    input  logic           advance,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic signed [W-1:0] ONE = W'(1);

    // Between load and setup, a/b/a_end/b_end hold the raw x0/y0/x1/y1.
    logic signed [W-1:0] a, b, a_end, b_end, dx, dy, err;
    logic                steep, ydown;

    logic signed [W-1:0] adx, ady, ux0, uy0, ux1, uy1, sx0, sy0, sx1, sy1, sdx, sdy, err_nx;
    logic                steep_nx, flip;

    assign adx      = (a_end >= a) ? a_end - a : a - a_end;
    assign ady      = (b_end >= b) ? b_end - b : b - b_end;
    assign steep_nx = ady > adx;
    assign ux0      = steep_nx ? b : a;
    assign uy0      = steep_nx ? a : b;
    assign ux1      = steep_nx ? b_end : a_end;
    assign uy1      = steep_nx ? a_end : b_end;
    assign flip     = ux0 > ux1;
    assign sx0      = flip ? ux1 : ux0;
    assign sy0      = flip ? uy1 : uy0;
    assign sx1      = flip ? ux0 : ux1;
    assign sy1      = flip ? uy0 : uy1;
    assign sdx      = sx1 - sx0;
    assign sdy      = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
    assign err_nx   = err - dy;

    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            a_end <= '0;
            b_end <= '0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
            steep <= 1'b0;
            ydown <= 1'b0;
        end else if (load) begin
            a     <= W'(x0);
            b     <= W'(y0);
            a_end <= W'(x1);
            b_end <= W'(y1);
        end else if (setup) begin
            a     <= sx0;
            b     <= sy0;
            a_end <= sx1;
            dx    <= sdx;
            dy    <= sdy;
            err   <= sdx >>> 1;
            steep <= steep_nx;
            ydown <= sy1 < sy0;
        end else if (advance) begin
            a <= a + ONE;
            if (err_nx[W-1]) begin
                b   <= ydown ? b - ONE : b + ONE;
                err <= err_nx + dx;
            end else begin
                err <= err_nx;
            end
        end
    end

    assign x    = steep ? b[X_W-1:0] : a[X_W-1:0];
    assign y    = steep ? a[Y_W-1:0] : b[Y_W-1:0];
    assign last = (a == a_end);

endmodule

// File: rtl/burst_line_engine.sv
// Line rasteriser that coalesces pixels of one 8-pixel block into a two-beat DDR burst.
// Optional clipping to H_RES x V_RES is enabled by defining BURST_LINE_CLIP_EN.
module burst_line_engine
    import line_engine_pkg::*;
#(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int ROW_SHIFT = 9,
    parameter int H_RES     = 800,
    parameter int V_RES     = 600
) (
    input  logic               clk,
    input  logic               rst,
    output logic               LE_ready,
    input  logic [31:0]        LE_color,
    input  logic               LE_color_valid,
    input  logic [X_W+Y_W-1:0] LE_point,
    input  logic               LE_point0_valid,
    input  logic               LE_point1_valid,
    input  logic               LE_trigger,
    input  logic [31:0]        LE_frame_base,
    input  logic               af_full,
    input  logic               wdf_full,
    output logic [2:0]         af_cmd_din,
    output logic [30:0]        af_addr_din,
    output logic               af_wr_en,
    output logic [127:0]       wdf_din,
    output logic [15:0]        wdf_mask_din,
    output logic               wdf_wr_en
);

    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;

`ifdef BURST_LINE_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    le_state_t state, state_nx;

    logic [31:0]          color_r, line_color;
    logic [X_W+Y_W-1:0]   p0_r, p1_r;
    logic                 blk_valid, last_blk;
    logic [Y_W-1:0]       blk_y;
    logic [X_W-4:0]       blk_xhi;
    logic [PIX_PER_BLK-1:0] blk_pix;

    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic           last, advance, take_pix, pix_ok, key_match, load;
    logic [30:0]    blk_addr;

    assign load = (state == ST_IDLE) && LE_trigger;

    line_stepper #(.X_W(X_W), .Y_W(Y_W), .W(W)) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .setup   (state == ST_SETUP),
        .advance (advance),
        .x0      (p0_r[X_W+Y_W-1:Y_W]),
        .y0      (p0_r[Y_W-1:0]),
        .x1      (p1_r[X_W+Y_W-1:Y_W]),
        .y1      (p1_r[Y_W-1:0]),
        .x       (cur_x),
        .y       (cur_y),
        .last    (last)
    );

    assign pix_ok    = !CLIP_ON || ((32'(cur_x) < H_RES) && (32'(cur_y) < V_RES));
    assign key_match = (cur_y == blk_y) && (cur_x[X_W-1:3] == blk_xhi);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A pixel from a different block waits in STEP (no advance) until the pending block drains.
    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        take_pix = 1'b0;
        case (state)
            ST_IDLE:   if (LE_trigger) state_nx = ST_SETUP;
            ST_SETUP:  state_nx = ST_STEP;
            ST_STEP: begin
                if (blk_valid && !key_match) begin
                    state_nx = ST_FLUSH0;
                end else begin
                    take_pix = 1'b1;
                    advance  = !last;
                    if (last) state_nx = (blk_valid || pix_ok) ? ST_FLUSH0 : ST_IDLE;
                end
            end
            ST_FLUSH0: if (!af_full && !wdf_full) state_nx = ST_FLUSH1;
            ST_FLUSH1: if (!wdf_full) state_nx = last_blk ? ST_IDLE : ST_STEP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Colour is snapshotted at trigger so a same-cycle colour write only affects the next line.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_r    <= '0;
            line_color <= '0;
            p0_r       <= '0;
            p1_r       <= '0;
            blk_valid  <= 1'b0;
            last_blk   <= 1'b0;
            blk_y      <= '0;
            blk_xhi    <= '0;
            blk_pix    <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (LE_color_valid)  color_r <= LE_color;
                if (LE_point0_valid) p0_r    <= LE_point;
                if (LE_point1_valid) p1_r    <= LE_point;
                if (LE_trigger) begin
                    line_color <= color_r;
                    last_blk   <= 1'b0;
                    blk_valid  <= 1'b0;
                    blk_pix    <= '0;
                end
            end
            if (take_pix && pix_ok) begin
                blk_valid        <= 1'b1;
                blk_y            <= cur_y;
                blk_xhi          <= cur_x[X_W-1:3];
                blk_pix[cur_x[2:0]] <= 1'b1;
            end
            if (take_pix && last) last_blk <= 1'b1;
            if ((state == ST_FLUSH1) && !wdf_full) begin
                blk_valid <= 1'b0;
                blk_pix   <= '0;
            end
        end
    end

    assign blk_addr = 31'(LE_frame_base >> 3) + (31'(blk_y) << ROW_SHIFT) + 31'({blk_xhi, 2'b00});

    assign LE_ready     = (state == ST_IDLE);
    assign af_cmd_din   = AF_CMD_WRITE;
    assign af_wr_en     = (state == ST_FLUSH0) && !af_full && !wdf_full;
    assign wdf_wr_en    = af_wr_en || ((state == ST_FLUSH1) && !wdf_full);
    assign af_addr_din  = (state == ST_FLUSH0) ? blk_addr : '0;
    assign wdf_din      = ((state == ST_FLUSH0) || (state == ST_FLUSH1)) ? {4{line_color}} : '0;
    assign wdf_mask_din = (state == ST_FLUSH0) ? expand_mask(blk_pix[3:0]) :
                          (state == ST_FLUSH1) ? expand_mask(blk_pix[7:4]) : MASK_ALL_OFF;

endmodule

// File: tb/tb_burst_line_engine.sv
// Directed bench for burst_line_engine: captures every burst pushed into the DDR FIFOs
// and compares against hand-computed bursts or a small Bresenham reference.
module tb_burst_line_engine;

    localparam logic [31:0] BASE   = 32'h10400000;
    localparam logic [30:0] BASE_U = 31'h2080000;

    logic         clk = 1'b0;
    logic         rst;
    logic         LE_ready;
    logic [31:0]  LE_color;
    logic         LE_color_valid;
    logic [19:0]  LE_point;
    logic         LE_point0_valid;
    logic         LE_point1_valid;
    logic         LE_trigger;
    logic [31:0]  LE_frame_base;
    logic         af_full;
    logic         wdf_full;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;

    int checks = 0;
    int fails  = 0;
    int viol   = 0;

    logic [30:0]  got_addr[$];
    logic [15:0]  got_m0[$];
    logic [15:0]  got_m1[$];
    logic [127:0] got_d0[$];
    logic [127:0] got_d1[$];
    logic [30:0]  exp_addr[$];
    logic [15:0]  exp_m0[$];
    logic [15:0]  exp_m1[$];

    always #5 clk = ~clk;

    burst_line_engine dut (
        .clk             (clk),
        .rst             (rst),
        .LE_ready        (LE_ready),
        .LE_color        (LE_color),
        .LE_color_valid  (LE_color_valid),
        .LE_point        (LE_point),
        .LE_point0_valid (LE_point0_valid),
        .LE_point1_valid (LE_point1_valid),
        .LE_trigger      (LE_trigger),
        .LE_frame_base   (LE_frame_base),
        .af_full         (af_full),
        .wdf_full        (wdf_full),
        .af_cmd_din      (af_cmd_din),
        .af_addr_din     (af_addr_din),
        .af_wr_en        (af_wr_en),
        .wdf_din         (wdf_din),
        .wdf_mask_din    (wdf_mask_din),
        .wdf_wr_en       (wdf_wr_en)
    );

    // Bursts are recorded mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if ((af_wr_en && (af_full || wdf_full)) || (wdf_wr_en && wdf_full)) viol++;
            if (af_wr_en) begin
                got_addr.push_back(af_addr_din);
                got_m0.push_back(wdf_mask_din);
                got_d0.push_back(wdf_din);
            end else if (wdf_wr_en) begin
                got_m1.push_back(wdf_mask_din);
                got_d1.push_back(wdf_din);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearCapture();
        got_addr.delete(); got_m0.delete(); got_m1.delete(); got_d0.delete(); got_d1.delete();
        exp_addr.delete(); exp_m0.delete(); exp_m1.delete();
        viol = 0;
    endtask

    task automatic pushExp(input logic [30:0] addr, input logic [15:0] m0, input logic [15:0] m1);
        exp_addr.push_back(addr);
        exp_m0.push_back(m0);
        exp_m1.push_back(m1);
    endtask

    task automatic pushBlock(input int bx, input int by, input logic [7:0] pix);
        logic [31:0] m = '1;
        for (int i = 0; i < 8; i++) if (pix[i]) m[31-4*i -: 4] = 4'h0;
        pushExp(BASE_U + 31'(by << 9) + 31'(bx * 4), m[31:16], m[15:0]);
    endtask

    // Reference Bresenham with block coalescing, used for the long stalled line.
    task automatic modelLine(input int x0, input int y0, input int x1, input int y1);
        int t, dx, dy, err, ystep, y, bx, by, px, py;
        bit steep, have, ok;
        logic [7:0] pix;
        steep = ((y1 > y0) ? y1 - y0 : y0 - y1) > ((x1 > x0) ? x1 - x0 : x0 - x1);
        if (steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx = x1 - x0;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        err = dx / 2;
        ystep = (y0 < y1) ? 1 : -1;
        y = y0; have = 0; pix = '0; bx = 0; by = 0;
        for (int x = x0; x <= x1; x++) begin
            px = steep ? y : x;
            py = steep ? x : y;
            if (have && (py != by || px / 8 != bx)) begin
                pushBlock(bx, by, pix);
                have = 0; pix = '0;
            end
`ifdef BURST_LINE_CLIP_EN
            ok = (px < 800) && (py < 600);
`else
            ok = 1'b1;
`endif
            if (ok) begin
                if (!have) begin have = 1; bx = px / 8; by = py; end
                pix[px % 8] = 1'b1;
            end
            err -= dy;
            if (err < 0) begin y += ystep; err += dx; end
        end
        if (have) pushBlock(bx, by, pix);
    endtask

    // Loads colour and endpoints, then triggers; junk drives a colour write alongside the trigger.
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input logic [31:0] color, input bit junk);
        @(posedge clk); #1;
        LE_color = color; LE_color_valid = 1'b1;
        LE_point = {10'(x0), 10'(y0)}; LE_point0_valid = 1'b1;
        @(posedge clk); #1;
        LE_color_valid = 1'b0; LE_point0_valid = 1'b0;
        LE_point = {10'(x1), 10'(y1)}; LE_point1_valid = 1'b1;
        @(posedge clk); #1;
        LE_point1_valid = 1'b0; LE_trigger = 1'b1;
        if (junk) begin LE_color = 32'hDEADBEEF; LE_color_valid = 1'b1; end
        @(posedge clk); #1;
        LE_trigger = 1'b0; LE_color_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!LE_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, 128'(LE_ready), 128'(1));
    endtask

    task automatic compareBursts(input string tag, input logic [31:0] color);
        int bad = 0;
        logic [15:0] m0, m1;
        logic [127:0] d0, d1;
        checkOutput({tag, "_n_af"}, 128'(got_addr.size()), 128'(exp_addr.size()));
        checkOutput({tag, "_n_beat1"}, 128'(got_m1.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i >= got_addr.size() || i >= got_m1.size()) begin
                bad++;
            end else begin
                m0 = got_m0[i]; m1 = got_m1[i]; d0 = got_d0[i]; d1 = got_d1[i];
                if (got_addr[i] !== exp_addr[i] || m0 !== exp_m0[i] || m1 !== exp_m1[i]) bad++;
                for (int w = 0; w < 4; w++) begin
                    if (m0[15-4*w -: 4] == 4'h0 && d0[127-32*w -: 32] !== color) bad++;
                    if (m1[15-4*w -: 4] == 4'h0 && d1[127-32*w -: 32] !== color) bad++;
                end
            end
        end
        checkOutput({tag, "_bursts"}, 128'(bad), 128'(0));
        checkOutput({tag, "_no_push_full"}, 128'(viol), 128'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        LE_color = '0; LE_color_valid = 1'b0; LE_point = '0;
        LE_point0_valid = 1'b0; LE_point1_valid = 1'b0; LE_trigger = 1'b0;
        LE_frame_base = BASE; af_full = 1'b0; wdf_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 128'(LE_ready), 128'(1));
        checkOutput("rst_af_wr", 128'(af_wr_en), 128'(0));
        checkOutput("rst_wdf_wr", 128'(wdf_wr_en), 128'(0));
        checkOutput("rst_mask", 128'(wdf_mask_din), 128'(16'hFFFF));
        checkOutput("rst_addr", 128'(af_addr_din), 128'(0));
        checkOutput("rst_din", wdf_din, 128'(0));
        checkOutput("rst_cmd", 128'(af_cmd_din), 128'(0));

        $display("[TB] horizontal 8-pixel block");
        clearCapture();
        pushExp(BASE_U, 16'h0000, 16'h0000);
        applyStimulus(0, 0, 7, 0, 32'h007F0000, 1'b0);
        waitIdle("t1", 200);
        compareBursts("t1", 32'h007F0000);

        $display("[TB] vertical line, colour write during trigger ignored");
        clearCapture();
        for (int i = 0; i < 4; i++) pushExp(BASE_U + 31'(i * 32'h200), 16'hFFFF, 16'hF0FF);
        applyStimulus(5, 0, 5, 3, 32'h00FF00FF, 1'b1);
        waitIdle("t2", 200);
        compareBursts("t2", 32'h00FF00FF);

        $display("[TB] diagonal in both directions");
        for (int dir = 0; dir < 2; dir++) begin
            clearCapture();
            pushExp(BASE_U,           16'h0FFF, 16'hFFFF);
            pushExp(BASE_U + 31'h200, 16'hF0FF, 16'hFFFF);
            pushExp(BASE_U + 31'h400, 16'hFF0F, 16'hFFFF);
            pushExp(BASE_U + 31'h600, 16'hFFF0, 16'hFFFF);
            if (dir == 0) applyStimulus(3, 3, 0, 0, 32'h12345678, 1'b0);
            else          applyStimulus(0, 0, 3, 3, 32'h12345678, 1'b0);
            waitIdle((dir == 0) ? "t3_rev" : "t3_fwd", 200);
            compareBursts((dir == 0) ? "t3_rev" : "t3_fwd", 32'h12345678);
        end

        $display("[TB] long line with FIFO back-pressure");
        clearCapture();
        modelLine(0, 0, 1000, 700);
        applyStimulus(0, 0, 1000, 700, 32'hA5A5A5A5, 1'b0);
        repeat (40) @(posedge clk);
        #1 af_full = 1'b1;
        repeat (20) @(posedge clk);
        #1 af_full = 1'b0;
        n = 0;
        @(negedge clk);
        while (!af_wr_en && n < 100) begin @(negedge clk); n++; end
        checkOutput("t4_af_push_seen", 128'(af_wr_en), 128'(1));
        @(posedge clk); #1 wdf_full = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_hold_beat1", 128'(wdf_wr_en), 128'(0));
        @(posedge clk); #1 wdf_full = 1'b0;
        waitIdle("t4", 20000);
        compareBursts("t4", 32'hA5A5A5A5);

        $display("[TB] single-pixel line");
        clearCapture();
        pushExp(BASE_U + 31'h1204, 16'hF0FF, 16'hFFFF);
        applyStimulus(9, 9, 9, 9, 32'h0000FF00, 1'b0);
        waitIdle("t5", 200);
        compareBursts("t5", 32'h0000FF00);

        $display("[TB] reset in the middle of a line");
        clearCapture();
        applyStimulus(0, 0, 1000, 700, 32'h11111111, 1'b0);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_rst_af_wr", 128'(af_wr_en), 128'(0));
        checkOutput("t5_rst_wdf_wr", 128'(wdf_wr_en), 128'(0));
        checkOutput("t5_rst_ready", 128'(LE_ready), 128'(1));
        checkOutput("t5_rst_mask", 128'(wdf_mask_din), 128'(16'hFFFF));
        @(posedge clk); #1 rst = 1'b0;
        clearCapture();
        repeat (10) @(posedge clk);
        checkOutput("t5_no_orphan", 128'(got_addr.size()), 128'(0));
        pushExp(BASE_U, 16'h0000, 16'h0000);
        applyStimulus(0, 0, 7, 0, 32'h007F0000, 1'b0);
        waitIdle("t5_after", 200);
        compareBursts("t5_after", 32'h007F0000);

        $display("[TB] line crossing the horizontal clip boundary");
        clearCapture();
        pushExp(BASE_U + 31'h1588, 16'hFFFF, 16'hFF00);
        pushExp(BASE_U + 31'h158C, 16'h0000, 16'h0000);
`ifndef BURST_LINE_CLIP_EN
        pushExp(BASE_U + 31'h1590, 16'h0000, 16'h0000);
        pushExp(BASE_U + 31'h1594, 16'h00FF, 16'hFFFF);
`endif
        applyStimulus(790, 10, 809, 10, 32'h00C0FFEE, 1'b0);
        waitIdle("t6", 300);
        compareBursts("t6", 32'h00C0FFEE);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
